// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // flags are {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~(c & ~z);
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = ~(~z & (n == v));
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/main_fsm.sv
// Moore main FSM: state register, next-state logic and per-state datapath controls.
module main_fsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    output logic       is_decode,
    output logic       ir_write,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       alu_op,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src
);

    state_t state_q, state_d;
    state_t cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct5 ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct0 ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the controls decode as FETCH; the enables are masked by the parent.
    always_comb begin
        cur        = reset ? S_FETCH : state_q;
        is_decode  = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_WD;
        result_src = RES_ALUOUT;
        case (cur)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
            end
            S_DECODE: begin
                is_decode  = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: begin
                alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_ALUOUT;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Multicycle ARM control unit: instruction decode, condition logic with flags register,
// and the main FSM producing all datapath selects and enables.
module controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    logic is_decode, ir_write, next_pc, reg_w, mem_w, branch, alu_op;

    main_fsm u_main_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct5     (funct[5]),
        .funct0     (funct[0]),
        .is_decode  (is_decode),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .alu_op     (alu_op),
        .adr_src    (AdrSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .result_src (ResultSrc)
    );

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

    logic [1:0] flag_w;

    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ((funct[4:1] == CMD_ADD) | (funct[4:1] == CMD_SUB));
        end
    end

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_r_q, cond_ex_r_d;
    logic       cond_ex;

    assign cond_ex = cond_check(cond, flags_q);

    always_comb begin
        cond_ex_r_d = is_decode ? cond_ex : cond_ex_r_q;
        flags_d     = flags_q;
        if (flag_w[1] & cond_ex_r_q) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (flag_w[0] & cond_ex_r_q) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= '0;
            cond_ex_r_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cond_ex_r_q <= cond_ex_r_d;
        end
    end

    // reg_w is only raised in the write-back states, so PCS there reduces to Rd==15.
    logic pcs;
    assign pcs = ((rd == 4'hF) & reg_w) | branch;

    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_r_q));
    assign RegWrite = ~reset & reg_w & cond_ex_r_q;
    assign MemWrite = ~reset & mem_w & cond_ex_r_q;
    assign IRWrite  = ~reset & ir_write;

endmodule
